hazard_sequencer: RTL

Pipeline hazard and stall sequencer for the five-stage RISC-V core. It drives the stall, flush and forwarding controls of the F/D/E/M/W pipeline registers, including the stage-to-stage control registers. It resolves RAW hazards by forwarding, load-use stalls and taken-branch flushes. It also runs the request/ready handshake with a variable-latency data memory, freezing the pipeline until the access completes or times out.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_sequencer_forward_unit.sv | 24 ++
 rtl/hazard_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Purpose: shared types and helpers for the hazard sequencer block.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package hazard_pkg;

  // ALU operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Data-memory handshake FSM
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_fsm_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Forward from the youngest producer that writes a non-x0 register matching rs.
  // M is younger than W, so it takes priority.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_M;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sequencer_forward_unit.sv
// Purpose: RAW forwarding compare for both ALU operands in Execute.
// Latency: combinational, zero cycles.
// Backpressure: none; independent of stalls and flushes.
//
// Ports: i_rs1_e/i_rs2_e  Execute source regs
//        i_rd_m/i_reg_write_m, i_rd_w/i_reg_write_w  producer regs in M / W
//        o_fwd_a/o_fwd_b  operand selects (00 regfile, 01 W, 10 M)
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs1_e,
  input  logic [4:0] i_rs2_e,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  assign o_fwd_a = fwd_select(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
  assign o_fwd_b = fwd_select(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);

endmodule

// File: rtl/hazard_sequencer.sv
// Purpose: stall/flush/forward control for the 5-stage core plus data-memory handshake.
// Latency: all controls combinational from inputs and FSM state; MemTimeout is registered.
// Backpressure: a pending memory access freezes F/D/E/M until ready or timeout.
//
// Ports: hazard inputs (Rs*/Rd*/RegWrite*/ResultSrcE/PCSrcE), memory handshake
//        (MemAccessM, MemReadyM -> MemReqM), pipeline controls (Stall*, Flush*,
//        Forward*E), sticky MemTimeout, and StallCount/FlushCount performance
//        counters which exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  input  logic       MemReadyM,
  output logic       MemReqM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
`endif
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_fsm_t    r_state;
  mem_fsm_t    w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_timeout;
  logic        w_timeout_hit;
  logic        w_mem_stall;
  logic        w_mem_req;
  logic        w_load_use;

  forward_unit u_forward_unit (
    .i_rs1_e       (Rs1E),
    .i_rs2_e       (Rs2E),
    .i_rd_m        (RdM),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RdW),
    .i_reg_write_w (RegWriteW),
    .o_fwd_a       (ForwardAE),
    .o_fwd_b       (ForwardBE)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  // Memory handshake: the request strobe fires only in the first (RUN) cycle of
  // an access; WAIT releases the stall in the same cycle ready or timeout occurs.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_stall    = 1'b0;
    w_mem_req      = 1'b0;
    w_timeout_hit  = 1'b0;
    case (r_state)
      RUN: begin
        if (MemAccessM) begin
          w_mem_req = 1'b1;
          if (!MemReadyM) begin
            w_mem_stall    = 1'b1;
            w_state_nxt    = WAIT;
            w_wait_cnt_nxt = '0;
          end
        end
      end
      WAIT: begin
        // Ready on the last wait cycle is a completion, not a timeout.
        if (MemReadyM) begin
          w_state_nxt = RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt   = RUN;
          w_timeout_hit = 1'b1;
        end else begin
          w_mem_stall    = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_load_use = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Priority: memory stall > taken branch > load-use. Branch and load-use are
  // simply deferred during a memory stall because the held stages re-present
  // them on release. Controls stay quiet while reset is asserted.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushW = 1'b0;
    end else if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign MemReqM    = rst_n & w_mem_req;
  assign MemTimeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Free-running counters; wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF)           r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushD || FlushE) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule
